// File: rtl/soc_system_boot_status.sv
// Boot-status input port with per-bit debounce, edge capture and a
// level interrupt, exposed as a four-word Avalon-MM slave.
//
// Register map (word address):
//   0 : filtered input level (read only)
//   1 : reads as zero, writes dropped
//   2 : interrupt mask (read/write)
//   3 : captured edges (read, write-1-to-clear)
module soc_system_boot_status #(
   parameter int WIDTH     = 8,
   parameter int DEBOUNCE  = 4,
   parameter int EDGE_TYPE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // Counters are 8 bits wide so any DEBOUNCE up to 255 fits.
   localparam int            CW      = 8;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] filt_next;
   logic [WIDTH-1:0] load;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] mask;
   logic [CW-1:0]    cnt      [WIDTH];
   logic [CW-1:0]    cnt_next [WIDTH];
   logic             wr_valid;
   logic             rd_valid;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   // Bus qualification: a transfer happens only while chipselect is high.
   // A write (write_n low) wins over read in the same cycle, so a read is
   // honoured only when write_n is high. Every access completes in one
   // cycle (no wait states); read data appears one clock after the read.
   assign wr_valid = chipselect && !write_n;
   assign rd_valid = chipselect && read && write_n;

   // Upper write data bits beyond WIDTH carry no meaning for this block.
   assign unused_wdata = ^writedata;

   // Debounce: a bit must disagree with filt for DEBOUNCE consecutive
   // edges before filt takes the new value; any agreement restarts the
   // count. The count never passes CNT_MAX, so it cannot wrap and retoggle.
   always_comb begin
      filt_next = filt;
      load      = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = '0;
         if (sync[i] != filt[i]) begin
            if (cnt[i] == CNT_MAX) begin
               load[i]      = 1'b1;
               filt_next[i] = sync[i];
            end else begin
               cnt_next[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   // Edge qualification: on a load, sync holds the value filt is taking.
   always_comb begin
      edge_set = '0;
      if (EDGE_TYPE == 0) begin
         edge_set = load & sync;
      end else if (EDGE_TYPE == 1) begin
         edge_set = load & ~sync;
      end else begin
         edge_set = load;
      end
   end

   // Write-1-to-clear mask for the edge register.
   always_comb begin
      edge_clr = '0;
      if (wr_valid && (address == ADDR_EDGE)) begin
         edge_clr = writedata[WIDTH-1:0];
      end
   end

   // Read mux, zero-extended to the bus width.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = filt;
         ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_q;
         default:   rd_mux = '0;
      endcase
   end

   // Synchronizer, debounce counters and filtered level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= '0;
         sync      <= '0;
         filt      <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync_meta <= in_port;
         sync      <= sync_meta;
         filt      <= filt_next;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   // Edge capture (set beats clear on the same bit), mask and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_q   <= '0;
         mask     <= '0;
         readdata <= '0;
      end else begin
         edge_q <= (edge_q & ~edge_clr) | edge_set;
         if (wr_valid && (address == ADDR_MASK)) begin
            mask <= writedata[WIDTH-1:0];
         end
         if (rd_valid) begin
            readdata <= rd_mux;
         end
      end
   end

   assign irq = |(edge_q & mask);

endmodule

// File: tb/tb_soc_system_boot_status.sv
// Bench for soc_system_boot_status: three instances (rising, falling,
// any edge) share one bus and one input port. A behavioural model tracks
// the expected state; reads are scored through an expected queue.
module tb_soc_system_boot_status;

   localparam int WIDTH = 8;
   localparam int DEB   = 4;

   // ---------------- clock / reset / DUT ----------------
   logic             clk;
   logic             reset;
   logic [1:0]       address;
   logic             chipselect;
   logic             read;
   logic             write_n;
   logic [31:0]      writedata;
   logic [WIDTH-1:0] in_port;
   logic [31:0]      rdata [3];
   logic [2:0]       irq_v;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   soc_system_boot_status #(.WIDTH(WIDTH), .DEBOUNCE(DEB), .EDGE_TYPE(0)) u_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[0]), .irq(irq_v[0]));

   soc_system_boot_status #(.WIDTH(WIDTH), .DEBOUNCE(DEB), .EDGE_TYPE(1)) u_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[1]), .irq(irq_v[1]));

   soc_system_boot_status #(.WIDTH(WIDTH), .DEBOUNCE(DEB), .EDGE_TYPE(2)) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[2]), .irq(irq_v[2]));

   // ---------------- behavioural model ----------------
   // filt flips when the synchronized input has shown the opposite value
   // at each of the last DEB clock edges since reset.
   logic [WIDTH-1:0] m_s1, m_s2, m_filt, m_mask;
   logic [WIDTH-1:0] new_filt, rise_v, fall_v, set_v, clr_v;
   logic [WIDTH-1:0] m_edge [3];
   logic [31:0]      m_rd   [3];
   logic [WIDTH-1:0] hist   [$];
   logic [95:0]      exp_q  [$];
   logic             all_mis;

   int n_cmp  = 0;
   int n_fail = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_s1   = '0;
         m_s2   = '0;
         m_filt = '0;
         m_mask = '0;
         for (int e = 0; e < 3; e++) begin
            m_edge[e] = '0;
            m_rd[e]   = '0;
         end
         hist.delete();
      end else begin
         hist.push_back(m_s2);
         if (hist.size() > DEB) void'(hist.pop_front());
         new_filt = m_filt;
         if (hist.size() == DEB) begin
            for (int i = 0; i < WIDTH; i++) begin
               all_mis = 1'b1;
               for (int k = 0; k < DEB; k++) begin
                  if (hist[k][i] == m_filt[i]) all_mis = 1'b0;
               end
               if (all_mis) new_filt[i] = ~m_filt[i];
            end
         end
         rise_v = new_filt & ~m_filt;
         fall_v = m_filt & ~new_filt;
         clr_v  = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
         if (chipselect && read && write_n) begin
            for (int e = 0; e < 3; e++) begin
               case (address)
                  2'd0:    m_rd[e] = {24'h0, m_filt};
                  2'd2:    m_rd[e] = {24'h0, m_mask};
                  2'd3:    m_rd[e] = {24'h0, m_edge[e]};
                  default: m_rd[e] = 32'h0;
               endcase
            end
            exp_q.push_back({m_rd[2], m_rd[1], m_rd[0]});
         end
         for (int e = 0; e < 3; e++) begin
            set_v     = (e == 0) ? rise_v : (e == 1) ? fall_v : (rise_v | fall_v);
            m_edge[e] = (m_edge[e] & ~clr_v) | set_v;
         end
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[WIDTH-1:0];
         m_filt = new_filt;
         m_s2   = m_s1;
         m_s1   = in_port;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: irq and held readdata against the model every cycle,
   // plus every completed read against the expected queue.
   task automatic check_state(input string tag);
      logic [95:0] exp;
      for (int e = 0; e < 3; e++) begin
         chk($sformatf("%s_irq%0d", tag, e), {31'b0, irq_v[e]}, {31'b0, |(m_edge[e] & m_mask)});
         chk($sformatf("%s_hold%0d", tag, e), rdata[e], m_rd[e]);
      end
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         for (int e = 0; e < 3; e++) begin
            chk($sformatf("%s_rd%0d", tag, e), rdata[e], exp[32*e +: 32]);
         end
      end
   endtask

   // ---------------- driver tasks (start and end on a falling edge) ----------------
   task automatic tick(input string tag);
      @(negedge clk);
      chipselect = 1'b0;
      read       = 1'b0;
      write_n    = 1'b1;
      check_state(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic bus_read(input logic [1:0] a, input string tag);
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      write_n    = 1'b1;
      tick(tag);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic rd, input string tag);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      read       = rd;
      tick(tag);
   endtask

   // Reset with a mask write held on the bus, which must be ignored.
   task automatic do_reset(input int n);
      reset      = 1'b1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      read       = 1'b0;
      address    = 2'd2;
      writedata  = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) @(negedge clk);
      reset      = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      check_state("reset");
   endtask

   // ---------------- directed then random sequence ----------------
   initial begin
      int r;
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      read       = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = '0;

      // reset state
      do_reset(3);
      chk("rst_irq", {29'b0, irq_v}, 32'h0);
      chk("rst_readdata", rdata[0], 32'h0);
      bus_read(2'd2, "rst_mask_rd");
      chk("rst_mask_ignored", rdata[0], 32'h0);

      // basic path: filt updates on the 6th edge after the change
      in_port = 8'h05;
      idle(5, "basic");
      bus_read(2'd0, "basic");
      chk("basic_pre_update", rdata[0], 32'h0);
      bus_read(2'd0, "basic");
      chk("basic_filt", rdata[0], 32'h5);
      bus_read(2'd3, "basic");
      chk("basic_edge_rise", rdata[0], 32'h5);
      chk("basic_edge_fall", rdata[1], 32'h0);

      // glitch of DEB-1 samples is rejected
      bus_write(2'd3, 32'hFF, 1'b0, "glitch");
      in_port = 8'h0D;
      idle(3, "glitch");
      in_port = 8'h05;
      idle(8, "glitch");
      bus_read(2'd0, "glitch");
      chk("glitch_filt", rdata[0], 32'h5);
      bus_read(2'd3, "glitch");
      chk("glitch_edge", rdata[2], 32'h0);

      // pulse of exactly DEB samples passes both ways
      in_port = 8'h0D;
      idle(4, "pulse4");
      in_port = 8'h05;
      idle(12, "pulse4");
      bus_read(2'd3, "pulse4");
      chk("pulse4_rise", rdata[0], 32'h8);
      chk("pulse4_fall", rdata[1], 32'h8);

      // irq on bit 2
      in_port = 8'h00;
      idle(8, "irq");
      bus_write(2'd3, 32'hFF, 1'b0, "irq");
      bus_write(2'd2, 32'h4, 1'b0, "irq");
      in_port = 8'h04;
      idle(5, "irq");
      chk("irq_before", {31'b0, irq_v[0]}, 32'h0);
      tick("irq");
      chk("irq_on_set", {31'b0, irq_v[0]}, 32'h1);
      chk("irq_fall_inst", {31'b0, irq_v[1]}, 32'h0);
      bus_write(2'd3, 32'h1, 1'b0, "irq");
      chk("irq_w1c_other", {31'b0, irq_v[0]}, 32'h1);
      bus_write(2'd3, 32'h4, 1'b0, "irq");
      chk("irq_w1c", {31'b0, irq_v[0]}, 32'h0);

      // mask written onto an already captured edge
      bus_write(2'd2, 32'h0, 1'b0, "mask");
      in_port = 8'h00;
      idle(8, "mask");
      chk("mask_off_irq", {31'b0, irq_v[1]}, 32'h0);
      bus_write(2'd2, 32'h4, 1'b0, "mask");
      chk("mask_on_irq", {31'b0, irq_v[1]}, 32'h1);
      bus_write(2'd3, 32'hFF, 1'b0, "mask");
      chk("mask_cleared_irq", {31'b0, irq_v[1]}, 32'h0);

      // W1C on the same edge as a new bit 1 capture: set wins
      in_port = 8'h02;
      idle(5, "simul");
      bus_write(2'd3, 32'h2, 1'b0, "simul");
      bus_read(2'd3, "simul");
      chk("simul_set_wins", rdata[0], 32'h2);

      // write with read high is not a read; unused address ignores writes
      bus_write(2'd0, 32'hAB, 1'b1, "wr_rd");
      chk("wr_rd_hold", rdata[0], 32'h2);
      bus_write(2'd1, 32'hFFFF_FFFF, 1'b0, "addr1");
      bus_read(2'd1, "addr1");
      chk("addr1_zero", rdata[0], 32'h0);
      bus_read(2'd0, "addr0");
      chk("addr0_wr_ignored", rdata[0], 32'h2);

      // falling and any-edge capture
      bus_write(2'd3, 32'hFF, 1'b0, "etype");
      in_port = 8'h00;
      idle(8, "etype");
      bus_read(2'd3, "etype");
      chk("etype_fall", rdata[1], 32'h2);
      chk("etype_rise_none", rdata[0], 32'h0);
      bus_write(2'd3, 32'hFF, 1'b0, "etype");
      in_port = 8'h01;
      idle(6, "etype");
      in_port = 8'h00;
      idle(8, "etype");
      bus_read(2'd3, "etype");
      chk("etype_any", rdata[2], 32'h1);
      bus_read(2'd3, "etype");
      chk("etype_any_sticky", rdata[2], 32'h1);
      bus_write(2'd3, 32'h1, 1'b0, "etype");
      bus_read(2'd3, "etype");
      chk("etype_any_cleared", rdata[2], 32'h0);

      // reset two clocks into a debounce
      bus_write(2'd2, 32'hFF, 1'b0, "midrst");
      in_port = 8'h81;
      idle(2, "midrst");
      do_reset(2);
      chk("midrst_irq", {29'b0, irq_v}, 32'h0);
      bus_read(2'd0, "midrst");
      chk("midrst_filt", rdata[0], 32'h0);
      bus_read(2'd2, "midrst");
      chk("midrst_mask", rdata[0], 32'h0);
      bus_read(2'd3, "midrst");
      chk("midrst_edge", rdata[2], 32'h0);
      idle(2, "midrst");
      bus_read(2'd0, "midrst");
      chk("midrst_pre_update", rdata[0], 32'h0);
      bus_read(2'd0, "midrst");
      chk("midrst_filt_after", rdata[0], 32'h81);
      bus_read(2'd3, "midrst");
      chk("midrst_edge_after", rdata[0], 32'h81);

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < WIDTH; b++) begin
            if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
         end
         r = $urandom_range(0, 15);
         if (r == 0 && $urandom_range(0, 9) == 0) begin
            do_reset($urandom_range(1, 3));
         end else if (r >= 1 && r <= 4) begin
            bus_read(2'($urandom_range(0, 3)), "rand");
         end else if (r == 5 || r == 6) begin
            bus_write(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), "rand");
         end else begin
            tick("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
